// File: rtl/if_fetch_stage.sv
// if_fetch_stage: program counter plus IF/ID pipeline register.
// Drives a word-aligned fetch address to a combinational instruction memory
// and captures the returned word together with its PC+4 for the ID stage.
//
// Control inputs are level requests sampled on each rising edge. There is no
// valid/ready handshake. Priority per edge is:
//   reset > redirect > stall > flush > normal fetch.
// A bubble is instr=0 (nop) with valid=0; the PC+4 field keeps its last value.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 32,
  parameter int          CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             branch_taken_i,
  input  logic [31:0]      branch_target_i,
  input  logic [31:0]      instr_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      if_id_pc_plus4_o,
  output logic [31:0]      if_id_instr_o,
  output logic             if_id_valid_o,
  output logic             addr_err_o,
  output logic [CNT_W-1:0] fetch_count_o
);

  // The memory size in bytes is held in 33 bits so a memory that fills the
  // whole 32-bit space does not overflow the comparison.
  localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) * 33'd4;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0] pc_next_seq;
  logic        fetch_in_range;
  logic        target_misaligned;

  // Next sequential PC wraps modulo 2^32. The range check uses the current PC.
  always_comb begin
    pc_next_seq       = pc_o + 32'd4;
    fetch_in_range    = ({1'b0, pc_o} < IMEM_BYTES);
    target_misaligned = (branch_target_i[1:0] != 2'b00);
  end

  // PC, IF/ID slot, sticky error flag and fetch counter, all updated together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_o             <= RESET_PC;
      if_id_pc_plus4_o <= 32'h0000_0000;
      if_id_instr_o    <= 32'h0000_0000;
      if_id_valid_o    <= 1'b0;
      addr_err_o       <= 1'b0;
      fetch_count_o    <= '0;
    end else if (branch_taken_i) begin
      // A redirect wins over stall and flush. The low address bits are
      // dropped, and a misaligned target is reported.
      pc_o          <= {branch_target_i[31:2], 2'b00};
      if_id_instr_o <= 32'h0000_0000;
      if_id_valid_o <= 1'b0;
      if (target_misaligned) begin
        addr_err_o <= 1'b1;
      end
    end else if (stall_i) begin
      // The PC holds. The slot also holds unless a flush arrives at the same
      // time, in which case the slot becomes a bubble.
      if (flush_i) begin
        if_id_instr_o <= 32'h0000_0000;
        if_id_valid_o <= 1'b0;
      end
    end else if (flush_i) begin
      pc_o          <= pc_next_seq;
      if_id_instr_o <= 32'h0000_0000;
      if_id_valid_o <= 1'b0;
    end else begin
      pc_o <= pc_next_seq;
      if (fetch_in_range) begin
        if_id_pc_plus4_o <= pc_next_seq;
        if_id_instr_o    <= instr_i;
        if_id_valid_o    <= 1'b1;
        if (fetch_count_o != CNT_MAX) begin
          fetch_count_o <= fetch_count_o + CNT_ONE;
        end
      end else begin
        // Out-of-range fetch: whatever memory returned is discarded, a bubble
        // is captured, and the PC still advances.
        if_id_instr_o <= 32'h0000_0000;
        if_id_valid_o <= 1'b0;
        addr_err_o    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed scenarios plus a randomized run. The outputs are
// compared every cycle against a behavioural model of the fetch stage.
module tb_if_fetch_stage;

  localparam int IMEM_WORDS = 32;
  localparam int CNT_W      = 5;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic             rst_i;
  logic             stall_i;
  logic             flush_i;
  logic             branch_taken_i;
  logic [31:0]      branch_target_i;
  logic [31:0]      instr_i;
  logic [31:0]      pc_o;
  logic [31:0]      if_id_pc_plus4_o;
  logic [31:0]      if_id_instr_o;
  logic             if_id_valid_o;
  logic             addr_err_o;
  logic [CNT_W-1:0] fetch_count_o;

  if_fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_WORDS(IMEM_WORDS),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .instr_i         (instr_i),
    .pc_o            (pc_o),
    .if_id_pc_plus4_o(if_id_pc_plus4_o),
    .if_id_instr_o   (if_id_instr_o),
    .if_id_valid_o   (if_id_valid_o),
    .addr_err_o      (addr_err_o),
    .fetch_count_o   (fetch_count_o)
  );

  // ---------------- instruction memory ----------------
  // Out-of-range addresses return a recognisable junk word. A fetch stage that
  // wrongly captures it is then easy to spot.
  logic [31:0] mem [IMEM_WORDS];
  assign instr_i = (pc_o < 32'(IMEM_WORDS * 4)) ? mem[pc_o[6:2]] : 32'hDEAD_BEEF;

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc, m_pp4, m_instr;
  bit          m_valid, m_err;
  int          m_cnt;

  function automatic void model_step(input bit rst, input bit stall, input bit flush,
                                     input bit br, input logic [31:0] tgt);
    if (rst) begin
      m_pc = 32'h0; m_pp4 = 32'h0; m_instr = 32'h0; m_valid = 0; m_err = 0; m_cnt = 0;
    end else if (br) begin
      m_pc = tgt & 32'hFFFF_FFFC;
      m_instr = 32'h0; m_valid = 0;
      if ((tgt % 4) != 0) m_err = 1;
    end else if (stall) begin
      if (flush) begin m_instr = 32'h0; m_valid = 0; end
    end else if (flush) begin
      m_pc = m_pc + 32'd4;
      m_instr = 32'h0; m_valid = 0;
    end else begin
      if (longint'(m_pc) < longint'(IMEM_WORDS) * 4) begin
        m_pp4 = m_pc + 32'd4;
        m_instr = mem[m_pc / 4];
        m_valid = 1;
        if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      end else begin
        m_instr = 32'h0; m_valid = 0; m_err = 1;
      end
      m_pc = m_pc + 32'd4;
    end
  endfunction

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check32("pc", pc_o, m_pc);
    check32("pc_plus4", if_id_pc_plus4_o, m_pp4);
    check32("instr", if_id_instr_o, m_instr);
    check32("valid", 32'(if_id_valid_o), 32'(m_valid));
    check32("addr_err", 32'(addr_err_o), 32'(m_err));
    check32("fetch_count", 32'(fetch_count_o), 32'(m_cnt));
  endtask

  // ---------------- driver ----------------
  // Called at a negative edge. It drives the inputs, lets one rising edge
  // pass, advances the model, and compares at the following negative edge.
  task automatic cycle(input bit rst, input bit stall, input bit flush,
                       input bit br, input logic [31:0] tgt);
    rst_i = rst; stall_i = stall; flush_i = flush;
    branch_taken_i = br; branch_target_i = tgt;
    @(posedge clk_i);
    model_step(rst, stall, flush, br, tgt);
    @(negedge clk_i);
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_i = 1; stall_i = 0; flush_i = 0; branch_taken_i = 0; branch_target_i = 32'h0;
    for (int i = 0; i < IMEM_WORDS; i++) mem[i] = $urandom;
    mem[0] = 32'h2008_0001; mem[1] = 32'h2009_0002;
    mem[2] = 32'h0109_5020; mem[3] = 32'h0000_0000;
    @(negedge clk_i);

    // Reset values
    cycle(1, 0, 0, 0, 32'h0);
    check32("rst_pc", pc_o, 32'h0);
    check32("rst_valid", 32'(if_id_valid_o), 32'h0);
    check32("rst_count", 32'(fetch_count_o), 32'h0);

    // Free-running fetch
    cycle(0, 0, 0, 0, 32'h0);
    check32("c1_pc", pc_o, 32'h4);
    check32("c1_pp4", if_id_pc_plus4_o, 32'h4);
    check32("c1_instr", if_id_instr_o, 32'h2008_0001);
    cycle(0, 0, 0, 0, 32'h0);
    check32("c2_pp4", if_id_pc_plus4_o, 32'h8);
    check32("c2_instr", if_id_instr_o, 32'h2009_0002);
    run(2);
    check32("c4_pc", pc_o, 32'h10);
    check32("c4_count", 32'(fetch_count_o), 32'h4);

    // Stall for 3 cycles while pc_o is 8
    cycle(1, 0, 0, 0, 32'h0);
    run(2);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 32'h0);
    check32("stall_pc", pc_o, 32'h8);
    check32("stall_pp4", if_id_pc_plus4_o, 32'h8);
    check32("stall_instr", if_id_instr_o, 32'h2009_0002);
    check32("stall_count", 32'(fetch_count_o), 32'h2);
    cycle(0, 0, 0, 0, 32'h0);
    check32("release_pp4", if_id_pc_plus4_o, 32'hC);
    check32("release_instr", if_id_instr_o, 32'h0109_5020);

    // Redirect wins over stall
    cycle(0, 1, 0, 1, 32'h40);
    check32("br_pc", pc_o, 32'h40);
    check32("br_valid", 32'(if_id_valid_o), 32'h0);
    check32("br_instr", if_id_instr_o, 32'h0);
    cycle(0, 0, 0, 0, 32'h0);
    check32("br_next_pp4", if_id_pc_plus4_o, 32'h44);
    check32("br_next_instr", if_id_instr_o, mem[16]);

    // Flush alone, then a misaligned redirect
    cycle(1, 0, 0, 0, 32'h0);
    run(4);
    cycle(0, 0, 1, 0, 32'h0);
    check32("flush_pc", pc_o, 32'h14);
    check32("flush_valid", 32'(if_id_valid_o), 32'h0);
    check32("flush_pp4_held", if_id_pc_plus4_o, 32'h10);
    cycle(0, 0, 0, 1, 32'h42);
    check32("mis_pc", pc_o, 32'h40);
    check32("mis_err", 32'(addr_err_o), 32'h1);
    run(10);
    check32("mis_err_sticky", 32'(addr_err_o), 32'h1);

    // End of memory and out-of-range fetch
    cycle(1, 0, 0, 0, 32'h0);
    cycle(0, 0, 0, 1, 32'h78);
    run(2);
    check32("last_pp4", if_id_pc_plus4_o, 32'h80);
    check32("last_instr", if_id_instr_o, mem[31]);
    check32("last_err", 32'(addr_err_o), 32'h0);
    cycle(0, 0, 0, 0, 32'h0);
    check32("oor_pc", pc_o, 32'h84);
    check32("oor_valid", 32'(if_id_valid_o), 32'h0);
    check32("oor_err", 32'(addr_err_o), 32'h1);
    check32("oor_count", 32'(fetch_count_o), 32'h2);

    // PC wraps to zero after the last word address
    cycle(0, 0, 0, 1, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 0, 32'h0);
    check32("wrap_pc", pc_o, 32'h0);

    // Reset during a stall
    cycle(0, 0, 0, 1, 32'h24);
    cycle(0, 1, 0, 0, 32'h0);
    check32("pre_rst_pc", pc_o, 32'h24);
    cycle(1, 1, 0, 0, 32'h0);
    check32("stall_rst_pc", pc_o, 32'h0);
    check32("stall_rst_err", 32'(addr_err_o), 32'h0);

    // Randomized run; the counter is narrow, so saturation is reached
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      case ($urandom_range(0, 3))
        0: tgt = 32'($urandom_range(0, IMEM_WORDS - 1)) * 4;
        1: tgt = 32'($urandom_range(0, IMEM_WORDS * 4 + 32));
        2: tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: tgt = $urandom;
      endcase
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 6) == 0, $urandom_range(0, 12) == 0, tgt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
